// File: rtl/mc_mainfsm.sv
// mc_mainfsm: main control FSM for the multicycle MIPS-subset core.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, and Moore-decodes the datapath enables, mux selects and aluop
// from the current state. The write enables are also qualified by rst_n, so
// none of them can be high while the core is held in reset.
module mc_mainfsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       instret,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t r_state;

    logic w_knownOp;
    logic w_irwrite;
    logic w_memwrite;
    logic w_regwrite;
    logic w_pcwrite;
    logic w_branch;
    logic w_instret;

    assign w_knownOp = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                       (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    // State sequencing; the memory-facing states wait on mem_ready and any
    // unused encoding falls back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_RTYPEEX;
                        OP_BEQ:       r_state <= S_BEQEX;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JEX;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
                S_RTYPEEX: r_state <= S_RTYPEWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls from the current state; only the
    // fetch/store handshakes and the NOP retire look at inputs directly.
    always_comb begin
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_instret  = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb   = 2'b11;
                w_instret = ~w_knownOp;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                w_instret  = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_instret  = mem_ready;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                w_instret  = 1'b1;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                w_branch  = 1'b1;
                w_instret = 1'b1;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_instret  = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_instret = 1'b1;
            end
            default: ;
        endcase
    end

    assign irwrite  = w_irwrite & rst_n;
    assign memwrite = w_memwrite & rst_n;
    assign regwrite = w_regwrite & rst_n;
    assign instret  = w_instret & rst_n;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & rst_n;
    assign state    = r_state;

endmodule

// File: doc/mc_mainfsm.md
# mc_mainfsm

Multicycle main control FSM for the 32-bit MIPS-subset core. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath enables and muxes. It also produces the 2-bit `aluop` consumed by the downstream ALU decoder, which combines it with `funct` to form `alucontrol`. It supports lw, sw, R-type, beq, addi and j, with a memory-ready handshake for variable-latency memory.

## Interface
- No parameters.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode field from the instruction register.
- `zero` in 1: ALU zero flag, used for beq.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write enable.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: register file write address select (0 = rt, 1 = rd).
- `memtoreg` out 1: write-back data select (0 = ALUOut, 1 = Data).
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select (0 = PC, 1 = A).
- `alusrcb` out 2: ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `pcsrc` out 2: next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `aluop` out 2: to the ALU decoder (00 = add, 01 = sub, 10 = use funct).
- `pcen` out 1: PC register enable.
- `instret` out 1: one-cycle pulse on the final cycle of every instruction.
- `state` out 4: current state, for debug and coverage.

## Operation
- Opcodes:
  - lw = 100011
  - sw = 101011
  - R-type = 000000
  - beq = 000100
  - addi = 001000
  - j = 000010
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when `mem_ready` is high; otherwise hold in FETCH.
  - DECODE → MEMADR for lw/sw, RTYPEEX, BEQEX, ADDIEX, or JEX according to `op`. Any other opcode → FETCH, executed as a NOP.
  - MEMADR → MEMRD for lw, MEMWR for sw. `op` is held stable by the IR.
  - MEMRD → MEMWB when `mem_ready` is high; otherwise hold.
  - MEMWR → FETCH when `mem_ready` is high; otherwise hold.
  - RTYPEEX → RTYPEWB, ADDIEX → ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.
- Outputs are Moore-decoded from `state`. Any signal not listed below is 0.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite = pcwrite = `mem_ready`.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWR: iord=1, memwrite=1. `memwrite` is held for the whole state.
  - MEMWB: regdst=0, memtoreg=1, regwrite = `mem_ready`-qualified write of the loaded data, i.e. regwrite=1 in MEMWB.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- `pcen` = pcwrite | (branch & `zero`). `pcwrite` and `branch` are internal signals.
- `instret` = 1 in these cases:
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX.
  - MEMWR with `mem_ready` high.
  - DECODE with an unknown opcode.

## Timing
- Reset:
  - While `rst_n` is low, `state` = FETCH immediately (asynchronous).
  - `irwrite`, `pcen`, `memwrite`, `regwrite` and `instret` are forced to 0. All other outputs show FETCH values.
  - After release, the first edge with `mem_ready` high loads the IR.
  - Reset mid-instruction abandons the instruction. No write enable may glitch high during or after the assertion.
- Cycles per instruction, with `mem_ready` tied high:
  - lw 5; sw 4; R-type 4; addi 4.
  - beq 3; j 3.
  - unknown opcode 2.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle. PC and IR update exactly once per fetch.
- `aluop` is valid in the same cycle as `state`. The downstream ALU decoder is combinational, so `alucontrol` is valid in that same cycle.

## Test plan
- Reset: pulse `rst_n` low mid-MEMWR (sw, `mem_ready`=0) → `state`=0 asynchronously, `memwrite`=0 immediately.
- R-type add, `op`=000000, `mem_ready`=1:
  - `state` sequence is 0,1,6,7,0.
  - `aluop`=10 in state 6.
  - `regwrite`=1 and `regdst`=1 only in state 7.
  - `instret` pulses once.
- lw with `mem_ready` low for 2 cycles in MEMRD:
  - `state` sequence is 0,1,2,3,3,3,4,0.
  - `iord`=1 only in state 3.
  - `memtoreg`=`regwrite`=1 in state 4.
- beq:
  - With `zero`=1: `pcen`=1 and `pcsrc`=01 in state 8.
  - With `zero`=0: `pcen`=0 in state 8.
  - In both cases `aluop`=01 and the instruction takes 3 cycles.
- Fetch stall, `mem_ready`=0 for 3 cycles:
  - `irwrite`=`pcen`=0 for those cycles.
  - Exactly one `irwrite`/`pcen` pulse on the ready cycle, then DECODE.
- Unknown opcode 111111: `state` sequence is 0,1,0; `instret` pulses in DECODE; no write enable asserts. Also test j (3 cycles, `pcsrc`=10) and addi (ADDIWB with `regdst`=0).
